// File: rtl/alu_in_req_scheduler.sv
// ---------------------------------------------------------------------------
// alu_in_req_scheduler
//
// Shares a single ALU (valid/ready request side, done/result completion side)
// between NUM_REQ requesters. Requests are granted round-robin, and only one
// operation is in flight at a time: grant -> issue -> wait for done -> respond.
// A completion timeout turns a missing alu_done into an error response.
//
// Ports
//   clk, rst                   rising-edge clock, synchronous active-high reset
//   req_valid/req_ready        per-requester handshake (ready is a one-hot pulse)
//   req_op/req_a/req_b         per-requester op and operands, packed by index
//   rsp_valid/rsp_result/rsp_err  one-hot one-cycle completion to the owner
//   alu_valid/alu_ready        request handshake toward the ALU
//   alu_op/alu_a/alu_b         captured op/operands presented to the ALU
//   alu_done/alu_result        one-cycle result strobe from the ALU
//   busy                       high whenever the scheduler is not idle
// ---------------------------------------------------------------------------
module alu_in_req_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int OP_WIDTH  = 8,
  parameter int RES_WIDTH = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [3*NUM_REQ-1:0]        req_op,
  input  logic [OP_WIDTH*NUM_REQ-1:0] req_a,
  input  logic [OP_WIDTH*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [RES_WIDTH-1:0]        rsp_result,
  output logic                        rsp_err,
  output logic                        alu_valid,
  input  logic                        alu_ready,
  output logic [2:0]                  alu_op,
  output logic [OP_WIDTH-1:0]         alu_a,
  output logic [OP_WIDTH-1:0]         alu_b,
  input  logic                        alu_done,
  input  logic [RES_WIDTH-1:0]        alu_result,
  output logic                        busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_RST = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  state_e                state_q, state_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [PTR_W-1:0]      owner_q, owner_d;
  logic [2:0]            op_q, op_d;
  logic [OP_WIDTH-1:0]   a_q, a_d;
  logic [OP_WIDTH-1:0]   b_q, b_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [RES_WIDTH-1:0]  rsp_result_q, rsp_result_d;
  logic                  rsp_err_q, rsp_err_d;

  logic                  grant_found;
  logic [PTR_W-1:0]      grant_idx;
  logic [PTR_W-1:0]      scan_idx;
  logic [2:0]            sel_op;
  logic [OP_WIDTH-1:0]   sel_a;
  logic [OP_WIDTH-1:0]   sel_b;

  // Only these codes reach the ALU; everything else behaves as no_op.
  function automatic logic needs_alu(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) ||
           (op == OP_MUL) || (op == OP_RST);
  endfunction

  // Round-robin pick: first asserted request at or after ptr_q, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scan_idx = PTR_W'((32'(ptr_q) + i) % NUM_REQ);
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    int unsigned g;
    g      = 32'(grant_idx);
    sel_op = req_op[3*g +: 3];
    sel_a  = req_a[OP_WIDTH*g +: OP_WIDTH];
    sel_b  = req_b[OP_WIDTH*g +: OP_WIDTH];
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    cnt_d        = cnt_q;
    rsp_valid_d  = '0;
    rsp_result_d = '0;
    rsp_err_d    = 1'b0;
    req_ready    = '0;
    alu_valid    = 1'b0;

    case (state_q)
      IDLE: begin
        // Grant suppressed while rst is high so no requester sees an accept
        // that the reset is about to discard.
        if (grant_found && !rst) begin
          req_ready[grant_idx] = 1'b1;
          owner_d = grant_idx;
          op_d    = sel_op;
          a_d     = sel_a;
          b_d     = sel_b;
          ptr_d   = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
          if (needs_alu(sel_op)) begin
            state_d = ISSUE;
          end else begin
            state_d              = RESP;
            rsp_valid_d[grant_idx] = 1'b1;
          end
        end
      end

      ISSUE: begin
        alu_valid = 1'b1;
        if (alu_ready) begin
          cnt_d = '0;
          if (op_q == OP_RST) begin
            state_d              = RESP;
            rsp_valid_d[owner_q] = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end

      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // Response is registered, so deciding one count early makes rsp_valid
        // land exactly TIMEOUT cycles after the ALU accept.
        if (alu_done) begin
          state_d              = RESP;
          rsp_valid_d[owner_q] = 1'b1;
          rsp_result_d         = alu_result;
        end else if (cnt_q == CNT_W'(TIMEOUT - 2)) begin
          state_d              = RESP;
          rsp_valid_d[owner_q] = 1'b1;
          rsp_err_d            = 1'b1;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      owner_q      <= '0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      cnt_q        <= '0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_err    = rsp_err_q;
  assign alu_op     = op_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign busy       = (state_q != IDLE);

endmodule
